exec_wb_stage: RTL and testbench

Execute/writeback stage that sits directly downstream of the 32x32 register bank.
- Accepts one decoded operation at a time: opcode, sr1, sr2, dr.
- Drives the bank's read-address ports and consumes its combinational read data.
- Computes the result with a single-cycle ALU, or an iterative 32-cycle shift-add multiplier for MUL.
- Returns the result through the bank's write port (wrData/dr/write) as a single-cycle write pulse.

---
 rtl/exec_wb_stage.sv | 187 ++++++++++++++++++
 tb/tb_exec_wb_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_wb_stage.sv
// exec_wb_stage
// Execute/writeback stage that sits directly behind a 32x32 register bank.
// It accepts one decoded operation at a time and reads both operands from the
// bank through its combinational read ports. It then computes the result,
// either with a single-cycle ALU or with a 32-iteration shift-add multiplier.
// The result goes back to the bank as a one-cycle write pulse.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   in_valid/in_ready  upstream handshake (ready only while idle)
//   opcode, sr1_in, sr2_in, dr_in   incoming decoded operation
//   sr1, sr2           latched read addresses to the bank
//   rdData1, rdData2   bank read data (combinational from sr1/sr2)
//   wrData, dr, write  bank write port (write is a one-cycle pulse)
//   busy               high whenever an operation is in flight
module exec_wb_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    sr1_in,
  input  logic [AW-1:0]    sr2_in,
  input  logic [AW-1:0]    dr_in,
  output logic [AW-1:0]    sr1,
  output logic [AW-1:0]    sr2,
  input  logic [WIDTH-1:0] rdData1,
  input  logic [WIDTH-1:0] rdData2,
  output logic [WIDTH-1:0] wrData,
  output logic [AW-1:0]    dr,
  output logic             write,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [3:0]       op;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    shamt;
  logic             last_iter;

  assign shamt     = rdData2[SW-1:0];
  assign last_iter = (cnt == SW'(WIDTH - 1));
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;

  // The write data is simply the result register. It is only meaningful
  // while write is high.
  assign wrData = result;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Undefined opcodes (11-15) leave EXEC straight for IDLE,
  // so they never produce a write pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = EXEC;
      EXEC: begin
        if (op == OP_MUL) begin
          next_state = MUL;
        end else if (op <= OP_SLTU) begin
          next_state = WB;
        end else begin
          next_state = IDLE;
        end
      end
      MUL:  if (last_iter) next_state = WB;
      WB:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status outputs. in_ready is also masked by reset, so an
  // operation presented during reset is never accepted.
  always_comb begin
    in_ready = (state == IDLE) && !reset;
    busy     = (state != IDLE);
    write    = (state == WB);
  end

  // Single-cycle ALU working on the bank read data of the EXEC cycle.
  // Shifts use only the low bits of operand 2.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = rdData1 + rdData2;
      OP_SUB:  alu_result = rdData1 - rdData2;
      OP_AND:  alu_result = rdData1 & rdData2;
      OP_OR:   alu_result = rdData1 | rdData2;
      OP_XOR:  alu_result = rdData1 ^ rdData2;
      OP_SLL:  alu_result = rdData1 << shamt;
      OP_SRL:  alu_result = rdData1 >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(rdData1) >>> shamt);
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(rdData1) < $signed(rdData2))};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (rdData1 < rdData2)};
      default: alu_result = '0;
    endcase
  end

  // Datapath registers.
  // The operation is captured at acceptance. Operands are consumed in EXEC,
  // either as an ALU result or as the multiplier seed.
  // The multiplier performs one shift-add step per MUL cycle. On the final
  // step the updated accumulator goes straight into result.
  always_ff @(posedge clk) begin
    if (reset) begin
      op     <= '0;
      sr1    <= '0;
      sr2    <= '0;
      dr     <= '0;
      result <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op  <= opcode;
            sr1 <= sr1_in;
            sr2 <= sr2_in;
            dr  <= dr_in;
          end
        end
        EXEC: begin
          if (op == OP_MUL) begin
            mcand  <= rdData1;
            mplier <= rdData2;
            acc    <= '0;
            cnt    <= '0;
          end else if (op <= OP_SLTU) begin
            result <= alu_result;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            result <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage
// Self-checking bench for exec_wb_stage. A behavioural 32x32 register bank
// is wired to the read and write ports of the stage. Every issued operation
// pushes its expected bank write onto a scoreboard queue. Write pulses
// observed on the bank port land in a second queue, and each test task pops
// and compares the two queues.
module tb_exec_wb_stage;

  typedef struct {
    logic [4:0]  dr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [4:0]  sr1_in, sr2_in, dr_in;
  logic [4:0]  sr1, sr2, dr;
  logic [31:0] rdData1, rdData2, wrData;
  logic        write, busy;

  logic [31:0] bank [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  write_count = 0;
  int  checks = 0;
  int  failures = 0;

  exec_wb_stage #(.WIDTH(32), .AW(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .sr1_in   (sr1_in),
    .sr2_in   (sr2_in),
    .dr_in    (dr_in),
    .sr1      (sr1),
    .sr2      (sr2),
    .rdData1  (rdData1),
    .rdData2  (rdData2),
    .wrData   (wrData),
    .dr       (dr),
    .write    (write),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural bank: combinational reads, and writes on the clock edge.
  // A stage write has priority over a bench preload.
  assign rdData1 = bank[sr1];
  assign rdData2 = bank[sr2];

  always @(posedge clk) begin
    if (write === 1'b1) bank[dr] <= wrData;
    else if (pre_we) bank[pre_addr] <= pre_data;
  end

  // Write-port monitor that feeds the observed queue.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      obs_q.push_back('{dr: dr, data: wrData});
      write_count++;
    end
  end

  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Present an operation and hold it until it is accepted. The task returns
  // at the negedge of the cycle after the accepting edge, which is the EXEC
  // cycle (latency 1).
  task automatic issue(input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    int n;
    opcode = op; sr1_in = s1; sr2_in = s2; dr_in = d; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("[TB] FAIL issue_timeout: in_ready never rose for opcode %0d", op);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a write pulse. Returns its latency in cycles from the accept
  // edge, or -1 if none arrives, and flags any in_ready seen while waiting.
  task automatic wait_write(output int lat, output bit ready_seen);
    lat = 1;
    ready_seen = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (write === 1'b1) break;
      if (in_ready === 1'b1) ready_seen = 1'b1;
    end
    if (lat >= 60) lat = -1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; opcode = 4'd0;
    sr1_in = 5'd1; sr2_in = 5'd2; dr_in = 5'd3; pre_we = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold: in_ready=%b busy=%b write=%b, required 0 0 0", in_ready, busy, write);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: in_ready=%b busy=%b write=%b, required 1 0 0", in_ready, busy, write);
    end
    checks++;
    if (sr1 !== 5'd0 || sr2 !== 5'd0 || dr !== 5'd0 || wrData !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_regs: sr1=%0d sr2=%0d dr=%0d wrData=%h, required all 0", sr1, sr2, dr, wrData);
    end
  endtask

  task automatic test_add;
    int lat; bit rs; wr_t e, o;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    exp_q.push_back('{dr: 5'd3, data: 32'd12});
    issue(4'd0, 5'd1, 5'd2, 5'd3);
    wait_write(lat, rs);
    checks++;
    if (lat != 2) begin
      failures++;
      $display("[TB] FAIL add_latency: got %0d cycles, required 2", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL add_write: no write observed, required dr=%0d data=%h", e.dr, e.data);
    end else begin
      o = obs_q.pop_front();
      if (o.data !== e.data || o.dr !== e.dr) begin
        failures++;
        $display("[TB] FAIL add_write: got dr=%0d data=%h, required dr=%0d data=%h", o.dr, o.data, e.dr, e.data);
      end
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL add_pulse_width: write=%b one cycle later, required 0", write);
    end
  endtask

  task automatic test_alu;
    vec_t vecs[11];
    int lat; bit rs; wr_t e, o;
    vecs = '{
      '{a: 32'h00000003, b: 32'hFFFFFFFE, op: 4'd1, exp: 32'h00000005},
      '{a: 32'h00000003, b: 32'hFFFFFFFE, op: 4'd8, exp: 32'h00000000},
      '{a: 32'h00000003, b: 32'hFFFFFFFE, op: 4'd9, exp: 32'h00000001},
      '{a: 32'h80000000, b: 32'h00000004, op: 4'd7, exp: 32'hF8000000},
      '{a: 32'h80000000, b: 32'h00000004, op: 4'd6, exp: 32'h08000000},
      '{a: 32'h00000001, b: 32'h00000023, op: 4'd5, exp: 32'h00000008},
      '{a: 32'hF0F0F0F0, b: 32'h0FF00FF0, op: 4'd2, exp: 32'h00F000F0},
      '{a: 32'hF0F0F0F0, b: 32'h0FF00FF0, op: 4'd3, exp: 32'hFFF0FFF0},
      '{a: 32'hF0F0F0F0, b: 32'h0FF00FF0, op: 4'd4, exp: 32'hFF00FF00},
      '{a: 32'hFFFFFFFF, b: 32'h00000001, op: 4'd8, exp: 32'h00000001},
      '{a: 32'hFFFFFFFF, b: 32'h00000002, op: 4'd0, exp: 32'h00000001}
    };
    for (int i = 0; i < 11; i++) begin
      preload(5'd1, vecs[i].a);
      preload(5'd2, vecs[i].b);
      exp_q.push_back('{dr: 5'(4 + i), data: vecs[i].exp});
      issue(vecs[i].op, 5'd1, 5'd2, 5'(4 + i));
      wait_write(lat, rs);
      checks++;
      if (lat != 2) begin
        failures++;
        $display("[TB] FAIL alu_latency[%0d]: got %0d cycles, required 2", i, lat);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL alu_write[%0d]: no write observed, required data=%h", i, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.dr !== e.dr) begin
          failures++;
          $display("[TB] FAIL alu_write[%0d] op %0d: got dr=%0d data=%h, required dr=%0d data=%h",
                   i, vecs[i].op, o.dr, o.data, e.dr, e.data);
        end
      end
    end
  endtask

  task automatic test_mul;
    logic [31:0] ma[5], mb[5];
    logic [31:0] prod;
    int lat; bit rs; wr_t e, o;
    ma[0] = 32'd1234;       mb[0] = 32'd5678;
    ma[1] = 32'hFFFFFFFF;   mb[1] = 32'hFFFFFFFF;
    ma[2] = 32'h00012345;   mb[2] = 32'd0;
    ma[3] = $urandom;       mb[3] = $urandom;
    ma[4] = $urandom;       mb[4] = $urandom;
    for (int i = 0; i < 5; i++) begin
      preload(5'd1, ma[i]);
      preload(5'd2, mb[i]);
      prod = ma[i] * mb[i];
      exp_q.push_back('{dr: 5'(i == 0 ? 7 : 16 + i), data: prod});
      issue(4'd10, 5'd1, 5'd2, 5'(i == 0 ? 7 : 16 + i));
      wait_write(lat, rs);
      checks++;
      if (lat != 34 || rs || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL mul_timing[%0d]: latency=%0d ready_seen=%b busy=%b, required 34 0 1", i, lat, rs, busy);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL mul_write[%0d]: no write observed, required data=%h", i, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.dr !== e.dr) begin
          failures++;
          $display("[TB] FAIL mul_write[%0d]: got dr=%0d data=%h, required dr=%0d data=%h", i, o.dr, o.data, e.dr, e.data);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int base, n; wr_t e, o;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    preload(5'd3, 32'd0);
    base = write_count;
    exp_q.push_back('{dr: 5'd3, data: 32'd12});
    exp_q.push_back('{dr: 5'd4, data: 32'd24});
    issue(4'd0, 5'd1, 5'd2, 5'd3);
    issue(4'd0, 5'd3, 5'd3, 5'd4);
    n = 0;
    while (write_count < base + 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL b2b_write[%0d]: no write observed, required dr=%0d data=%h", i, e.dr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.dr !== e.dr) begin
          failures++;
          $display("[TB] FAIL b2b_write[%0d]: got dr=%0d data=%h, required dr=%0d data=%h", i, o.dr, o.data, e.dr, e.data);
        end
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (write_count != base + 2) begin
      failures++;
      $display("[TB] FAIL b2b_accept_count: got %0d writes, required 2", write_count - base);
    end
  endtask

  task automatic test_reset_mid_mul;
    int base;
    preload(5'd1, 32'd1234);
    preload(5'd2, 32'd5678);
    base = write_count;
    issue(4'd10, 5'd1, 5'd2, 5'd9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_in_reset: busy=%b in_ready=%b write=%b, required 0 0 0", busy, in_ready, write);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || dr !== 5'd0 || sr1 !== 5'd0) begin
      failures++;
      $display("[TB] FAIL abort_release: in_ready=%b busy=%b dr=%0d sr1=%0d, required 1 0 0 0", in_ready, busy, dr, sr1);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (write_count != base) begin
      failures++;
      $display("[TB] FAIL abort_no_write: got %0d writes, required 0", write_count - base);
    end
  endtask

  task automatic test_nop;
    int base;
    base = write_count;
    issue(4'd13, 5'd1, 5'd2, 5'd11);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nop_return: busy=%b in_ready=%b at T+2, required 0 1", busy, in_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (write_count != base) begin
      failures++;
      $display("[TB] FAIL nop_no_write: got %0d writes, required 0", write_count - base);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
